delta_topic_consolidator: RTL and testbench

Consumer end of the theta→delta topic interface. It samples one episode salience value per theta_tick into a slot indexed by the incoming theta_cnt. When topic_last closes a topic, it reduces the closed slots to a topic summary (sum, peak, peak index, valid count) and presents the summary on a valid/ready handshake. It also checks that delta_tick arrives exactly where the closing theta predicts it. It sits downstream of the delta oscillator and upstream of topic-level memory/attention logic.

---
 rtl/delta_topic_consolidator_if.sv | 33 +++
 rtl/delta_topic_consolidator.sv | 211 +++++++++++++++++++++
 tb/tb_delta_topic_consolidator.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/delta_topic_consolidator_if.sv
// Topic summary handshake between the consolidator and its consumer.
// master drives the summary, slave returns topic_ready.
interface delta_topic_consolidator_if #(
  parameter int unsigned DATA_W = 8
);
  logic              topic_valid;
  logic              topic_ready;
  logic [DATA_W+2:0] topic_sum;
  logic [DATA_W-1:0] topic_peak;
  logic [2:0]        topic_peak_idx;
  logic [2:0]        topic_count;
  logic [7:0]        topic_id;

  modport master (
    output topic_valid,
    output topic_sum,
    output topic_peak,
    output topic_peak_idx,
    output topic_count,
    output topic_id,
    input  topic_ready
  );

  modport slave (
    input  topic_valid,
    input  topic_sum,
    input  topic_peak,
    input  topic_peak_idx,
    input  topic_count,
    input  topic_id,
    output topic_ready
  );
endinterface

// File: rtl/delta_topic_consolidator.sv
// Collects per-theta episode salience into a slot bank and reduces each
// closed delta topic into a sum/peak/count summary on a valid/ready port.
module delta_topic_consolidator #(
  parameter int unsigned DATA_W          = 8,
  parameter logic [2:0]  THETA_PER_DELTA = 3'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              theta_tick,
  input  logic [2:0]        theta_cnt,
  input  logic              topic_last,
  input  logic              delta_tick,
  input  logic              ep_valid,
  input  logic [DATA_W-1:0] ep_data,
  delta_topic_consolidator_if.master topic,
  output logic              topic_drop,
  output logic [7:0]        drop_cnt,
  output logic              sync_err
);

  localparam int unsigned NS = int'(THETA_PER_DELTA) + 1;
  localparam int unsigned SW = DATA_W + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_PRESENT
  } state_t;

  state_t            state_q, state_d;
  logic              wbank_q, wbank_d;
  logic              rbank;
  logic [DATA_W-1:0] bank_data_q [2][NS];
  logic [DATA_W-1:0] bank_data_d [2][NS];
  logic [NS-1:0]     bank_vld_q [2];
  logic [NS-1:0]     bank_vld_d [2];

  logic [3:0]        idx_q, idx_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [2:0]        rd_idx_q, rd_idx_d;

  logic [SW-1:0]     sum_q, sum_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [2:0]        pidx_q, pidx_d;
  logic [2:0]        count_q, count_d;
  logic              valid_q, valid_d;
  logic [7:0]        id_q, id_d;
  logic              drop_q, drop_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              sync_err_q, sync_err_d;
  logic              close_d1_q, close_d1_d;

  logic close;
  logic slot_ok;
  logic accept;
  logic busy;
  logic do_swap;

  assign rbank   = ~wbank_q;
  assign close   = theta_tick & topic_last;
  assign slot_ok = theta_cnt <= THETA_PER_DELTA;
  assign accept  = (state_q == S_PRESENT) & topic.topic_ready;
  assign busy    = (state_q == S_REDUCE) |
                   ((state_q == S_PRESENT) & ~topic.topic_ready);
  assign do_swap = close & ((state_q == S_IDLE) | accept);

  // Next-state: slot capture, reducer walk, bank swap/drop, framing check.
  always_comb begin
    state_d     = state_q;
    wbank_d     = wbank_q;
    bank_data_d = bank_data_q;
    bank_vld_d  = bank_vld_q;
    idx_d       = idx_q;
    rd_pend_d   = rd_pend_q;
    rd_vld_d    = rd_vld_q;
    rd_data_d   = rd_data_q;
    rd_idx_d    = rd_idx_q;
    sum_d       = sum_q;
    peak_d      = peak_q;
    pidx_d      = pidx_q;
    count_d     = count_q;
    valid_d     = valid_q;
    id_d        = id_q;
    drop_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    sync_err_d  = sync_err_q;
    close_d1_d  = close;

    if (theta_tick && slot_ok) begin
      bank_data_d[wbank_q][theta_cnt] = ep_data;
      bank_vld_d[wbank_q][theta_cnt]  = ep_valid;
    end

    unique case (state_q)
      S_IDLE: begin
      end
      S_REDUCE: begin
        // Slot read is registered; accumulate the previous fetch.
        if (rd_pend_q && rd_vld_q) begin
          sum_d   = sum_q + SW'(rd_data_q);
          count_d = count_q + 3'd1;
          if (rd_data_q > peak_q) begin
            peak_d = rd_data_q;
            pidx_d = rd_idx_q;
          end
        end
        if (idx_q <= {1'b0, THETA_PER_DELTA}) begin
          rd_data_d = bank_data_q[rbank][idx_q[2:0]];
          rd_vld_d  = bank_vld_q[rbank][idx_q[2:0]];
          rd_idx_d  = idx_q[2:0];
          rd_pend_d = 1'b1;
          idx_d     = idx_q + 4'd1;
        end else begin
          rd_pend_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (accept) begin
          valid_d = 1'b0;
          id_d    = id_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_swap) begin
      wbank_d           = rbank;
      bank_vld_d[rbank] = '0;
      state_d           = S_REDUCE;
      idx_d             = '0;
      rd_pend_d         = 1'b0;
      sum_d             = '0;
      peak_d            = '0;
      pidx_d            = '0;
      count_d           = '0;
    end

    if (close && busy) begin
      bank_vld_d[wbank_q] = '0;
      drop_d              = 1'b1;
      if (drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    if ((delta_tick != close_d1_q) || (theta_tick && !slot_ok))
      sync_err_d = 1'b1;
  end

  // Control and summary registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wbank_q    <= 1'b0;
      bank_vld_q <= '{default: '0};
      idx_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      sum_q      <= '0;
      peak_q     <= '0;
      pidx_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
      sync_err_q <= 1'b0;
      close_d1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wbank_q    <= wbank_d;
      bank_vld_q <= bank_vld_d;
      idx_q      <= idx_d;
      rd_pend_q  <= rd_pend_d;
      rd_vld_q   <= rd_vld_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
      sum_q      <= sum_d;
      peak_q     <= peak_d;
      pidx_q     <= pidx_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      sync_err_q <= sync_err_d;
      close_d1_q <= close_d1_d;
    end
  end

  // Slot payload storage; qualified by the valid bits, so no reset.
  always_ff @(posedge clk) begin
    bank_data_q <= bank_data_d;
  end

  assign topic.topic_valid    = valid_q;
  assign topic.topic_sum      = sum_q;
  assign topic.topic_peak     = peak_q;
  assign topic.topic_peak_idx = pidx_q;
  assign topic.topic_count    = count_q;
  assign topic.topic_id       = id_q;
  assign topic_drop           = drop_q;
  assign drop_cnt             = drop_cnt_q;
  assign sync_err             = sync_err_q;

endmodule

// File: tb/tb_delta_topic_consolidator.sv
// Bench for delta_topic_consolidator: vector table, corner sequences,
// and random deltas against a topic-level reference model.
module tb_delta_topic_consolidator;
  localparam int DW = 8;
  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          theta_tick;
  logic [2:0]    theta_cnt;
  logic          topic_last;
  logic          delta_tick;
  logic          ep_valid;
  logic [DW-1:0] ep_data;
  logic          topic_drop;
  logic [7:0]    drop_cnt;
  logic          sync_err;

  delta_topic_consolidator_if #(.DATA_W(DW)) tif();

  delta_topic_consolidator #(
    .DATA_W(DW),
    .THETA_PER_DELTA(3'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .theta_tick(theta_tick),
    .theta_cnt(theta_cnt),
    .topic_last(topic_last),
    .delta_tick(delta_tick),
    .ep_valid(ep_valid),
    .ep_data(ep_data),
    .topic(tif.master),
    .topic_drop(topic_drop),
    .drop_cnt(drop_cnt),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0][7:0] d;
    logic [4:0]      v;
    int              sum;
    int              peak;
    int              pidx;
    int              cnt;
  } vec_t;

  vec_t tbl[6];

  int checks = 0;
  int passed = 0;

  // Topic-level reference model
  logic [DW-1:0] ws_d[NS];
  bit            ws_v[NS];
  bit            m_have;
  int            m_valid_at;
  int            e;
  int            m_sum, m_peak, m_pidx, m_cnt;
  int            m_id;
  int            m_drops;
  bit            m_err;
  bit            m_drop_now;
  bit            prev_close;
  bit            flip_delta;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(logic [4:0][7:0] d, logic [4:0] v,
                              int s, int p, int i, int c);
    vec_t r;
    r.d = d; r.v = v; r.sum = s; r.peak = p; r.pidx = i; r.cnt = c;
    return r;
  endfunction

  function automatic bit rbit();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin ws_v[i] = 0; ws_d[i] = '0; end
    m_have = 0; m_valid_at = 0; e = 0;
    m_sum = 0; m_peak = 0; m_pidx = 0; m_cnt = 0;
    m_id = 0; m_drops = 0; m_err = 0; m_drop_now = 0;
    prev_close = 0; flip_delta = 0;
  endtask

  task automatic model_step();
    bit close, rdy, pres, busy;
    e++;
    close = theta_tick && topic_last;
    rdy   = tif.topic_ready;
    pres  = m_have && (e > m_valid_at);
    busy  = m_have && (!pres || !rdy);
    m_drop_now = 0;
    if (pres && rdy) begin
      m_have = 0;
      m_id = (m_id + 1) % 256;
    end
    if (delta_tick !== prev_close) m_err = 1;
    prev_close = close;
    if (theta_tick) begin
      if (int'(theta_cnt) < NS) begin
        ws_d[theta_cnt] = ep_data;
        ws_v[theta_cnt] = ep_valid;
      end else m_err = 1;
    end
    if (close) begin
      if (busy) begin
        m_drop_now = 1;
        if (m_drops < 255) m_drops++;
      end else begin
        m_sum = 0; m_peak = 0; m_pidx = 0; m_cnt = 0;
        for (int i = 0; i < NS; i++) begin
          if (ws_v[i]) begin
            m_sum += int'(ws_d[i]);
            m_cnt++;
            if (int'(ws_d[i]) > m_peak) begin
              m_peak = int'(ws_d[i]);
              m_pidx = i;
            end
          end
        end
        m_have = 1;
        m_valid_at = e + NS + 1;
      end
      for (int i = 0; i < NS; i++) ws_v[i] = 0;
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = m_have && (e >= m_valid_at);
    chk("valid", tif.topic_valid, 32'(ev));
    chk("id", tif.topic_id, m_id);
    chk("drop", topic_drop, 32'(m_drop_now));
    chk("drop_cnt", drop_cnt, m_drops);
    chk("sync_err", sync_err, 32'(m_err));
    if (ev) begin
      chk("sum", tif.topic_sum, m_sum);
      chk("peak", tif.topic_peak, m_peak);
      chk("peak_idx", tif.topic_peak_idx, m_pidx);
      chk("count", tif.topic_count, m_cnt);
    end
  endtask

  task automatic cyc(bit th, logic [2:0] cnt, bit last, bit v,
                     logic [7:0] d, bit rdy);
    theta_tick = th; theta_cnt = cnt; topic_last = last;
    ep_valid = v; ep_data = d; tif.topic_ready = rdy;
    delta_tick = prev_close ^ flip_delta;
    flip_delta = 0;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(bit rdy);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 8'd0, rdy);
  endtask

  task automatic delta_seq(logic [4:0][7:0] d, logic [4:0] v, bit rnd,
                           bit rdy, int maxgap);
    int gap;
    for (int i = 0; i < NS; i++) begin
      cyc(1'b1, 3'(i), i == NS - 1, v[i], d[i], rnd ? rbit() : rdy);
      if (i != NS - 1) begin
        gap = $urandom_range(0, maxgap);
        for (int g = 0; g < gap; g++) idle(rnd ? rbit() : rdy);
      end
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      idle(1'b0);
      if (tif.topic_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", tif.topic_valid, 0);
    chk("rst_id", tif.topic_id, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_sum", tif.topic_sum, 0);
    theta_tick = 0; topic_last = 0; delta_tick = 0; ep_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int lat;
    logic [4:0][7:0] rd;
    logic [4:0]      rv;

    tbl[0] = mk({8'd7, 8'd5, 8'd40, 8'd40, 8'd10}, 5'b11111, 102, 40, 1, 5);
    tbl[1] = mk({8'd9, 8'd255, 8'd50, 8'd255, 8'd200}, 5'b10101, 259, 200, 0, 3);
    tbl[2] = mk({8'd1, 8'd2, 8'd3, 8'd4, 8'd5}, 5'b00000, 0, 0, 0, 0);
    tbl[3] = mk({8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 5'b11111, 0, 0, 0, 5);
    tbl[4] = mk({8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 5'b11111, 1275, 255, 0, 5);
    tbl[5] = mk({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5'b11111, 15, 5, 4, 5);

    rst = 1'b1;
    theta_tick = 0; theta_cnt = 0; topic_last = 0; delta_tick = 0;
    ep_valid = 0; ep_data = 0; tif.topic_ready = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("reset_valid", tif.topic_valid, 0);
    chk("reset_sum", tif.topic_sum, 0);
    chk("reset_peak", tif.topic_peak, 0);
    chk("reset_idx", tif.topic_peak_idx, 0);
    chk("reset_count", tif.topic_count, 0);
    chk("reset_id", tif.topic_id, 0);
    chk("reset_drop", topic_drop, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    chk("reset_sync_err", sync_err, 0);
    rst = 1'b0;

    // Vector table: one delta each, held unaccepted until inspected
    for (int t = 0; t < 6; t++) begin
      delta_seq(tbl[t].d, tbl[t].v, 1'b0, 1'b0, 1);
      wait_valid(lat);
      chk("tbl_latency", lat, 6);
      chk("tbl_sum", tif.topic_sum, tbl[t].sum);
      chk("tbl_peak", tif.topic_peak, tbl[t].peak);
      chk("tbl_peak_idx", tif.topic_peak_idx, tbl[t].pidx);
      chk("tbl_count", tif.topic_count, tbl[t].cnt);
      idle(1'b1);
      chk("tbl_id", tif.topic_id, t + 1);
      chk("tbl_valid_fall", tif.topic_valid, 0);
    end

    // Close while presenting with ready low -> discarded
    delta_seq(tbl[0].d, tbl[0].v, 1'b0, 1'b0, 0);
    wait_valid(lat);
    delta_seq(tbl[1].d, tbl[1].v, 1'b0, 1'b0, 0);
    chk("drop_pulse", topic_drop, 1);
    chk("drop_cnt_one", drop_cnt, 1);
    idle(1'b0);
    chk("drop_pulse_end", topic_drop, 0);
    chk("held_sum", tif.topic_sum, 102);
    chk("held_peak", tif.topic_peak, 40);
    idle(1'b1);
    chk("drop_accept_id", tif.topic_id, 7);

    // Close on the accepting edge -> straight into reduce
    delta_seq(tbl[2].d, tbl[2].v, 1'b0, 1'b0, 0);
    wait_valid(lat);
    for (int i = 0; i < NS; i++)
      cyc(1'b1, 3'(i), i == NS - 1, tbl[3].v[i], tbl[3].d[i], i == NS - 1);
    chk("ac_nodrop", topic_drop, 0);
    chk("ac_id", tif.topic_id, 8);
    wait_valid(lat);
    chk("ac_latency", lat, 6);
    chk("ac_count", tif.topic_count, 5);
    idle(1'b1);

    // Reset during reduce, then during present
    delta_seq(tbl[0].d, tbl[0].v, 1'b0, 1'b1, 0);
    idle(1'b1);
    idle(1'b1);
    async_reset();
    delta_seq(tbl[1].d, tbl[1].v, 1'b0, 1'b0, 0);
    wait_valid(lat);
    chk("pres_before_rst", tif.topic_valid, 1);
    async_reset();
    delta_seq(tbl[4].d, tbl[4].v, 1'b0, 1'b0, 0);
    wait_valid(lat);
    chk("post_rst_id", tif.topic_id, 0);
    chk("post_rst_sum", tif.topic_sum, 1275);
    idle(1'b1);

    // Framing: missing delta_tick
    delta_seq(tbl[5].d, tbl[5].v, 1'b0, 1'b1, 0);
    flip_delta = 1;
    idle(1'b1);
    chk("miss_delta_err", sync_err, 1);
    for (int k = 0; k < 4; k++) idle(1'b1);
    chk("err_sticky", sync_err, 1);
    async_reset();

    // Framing: stray delta_tick
    idle(1'b1);
    flip_delta = 1;
    idle(1'b1);
    chk("stray_delta_err", sync_err, 1);
    async_reset();

    // Out-of-range slot index
    cyc(1'b1, 3'd6, 1'b0, 1'b1, 8'h33, 1'b1);
    chk("bad_cnt_err", sync_err, 1);
    async_reset();

    // Random deltas with random gaps and backpressure
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NS; i++) begin
        rd[i] = 8'($urandom_range(0, 255));
        rv[i] = 1'($urandom_range(0, 1));
      end
      delta_seq(rd, rv, 1'b1, 1'b0, 2);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) idle(rbit());
    end
    for (int k = 0; k < 10; k++) idle(1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
